// File: rtl/latch_sr_checker_if.sv
// rtl/latch_sr_checker_if.sv - Pin bundle between the checker and the set/reset latch under test
//
// Signals:
//   dut_d    : latch data input           (checker -> latch)
//   dut_clk  : latch enable, transparent=1 (checker -> latch)
//   dut_setb : active-low set, QN=0        (checker -> latch)
//   dut_rstb : active-low reset, QN=1      (checker -> latch)
//   dut_qn   : inverted latch output       (latch -> checker)
// Modports: master = checker side, slave = latch side.

interface latch_sr_checker_if;
    logic dut_d;
    logic dut_clk;
    logic dut_setb;
    logic dut_rstb;
    logic dut_qn;

    modport master (
        output dut_d,
        output dut_clk,
        output dut_setb,
        output dut_rstb,
        input  dut_qn
    );

    modport slave (
        input  dut_d,
        input  dut_clk,
        input  dut_setb,
        input  dut_rstb,
        output dut_qn
    );
endinterface

// File: rtl/latch_sr_checker.sv
// rtl/latch_sr_checker.sv - Sequencer that walks a set/reset latch through all 4-bit input vectors
//
// Ports:
//   CLK       : system clock, rising edge
//   RSTB      : asynchronous active-low reset
//   start     : one-cycle run request, only looked at while idle
//   lat       : latch pin bundle (master side)
//   busy      : run in progress
//   done      : one-cycle pulse at the end of a run
//   pass      : last run had no mismatches, held until the next start
//   err_count : mismatch count of current/last run, saturating
//   vec_idx   : index of the vector currently applied
//
// Vector v maps to pins as d=v[0], clk=v[1], rstb=v[2], setb=v[3].
// Every output is a flop; the output process computes next values from
// the upcoming state so pins change on the same edge as the state.

module latch_sr_checker #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  start,
    latch_sr_checker_if.master    lat,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [3:0]            vec_idx
);

    typedef enum logic [2:0] {
        IDLE, INIT, CLKLO, SETUP, APPLY, SETTLE, CHECK, DONE
    } state_t;

    // Counter must reach SETTLE_CYCLES (INIT lasts one cycle longer than SETTLE).
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAST_VEC    = 4'(NUM_VECTORS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             d_q, clk_q, setb_q, rstb_q;
    logic             d_nxt, clk_nxt, setb_nxt, rstb_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [3:0]       vec_nxt;
    logic             exp_qn, exp_nxt;

    assign lat.dut_d    = d_q;
    assign lat.dut_clk  = clk_q;
    assign lat.dut_setb = setb_q;
    assign lat.dut_rstb = rstb_q;

    // State register and registered outputs
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= IDLE;
            cnt       <= '0;
            d_q       <= 1'b0;
            clk_q     <= 1'b0;
            setb_q    <= 1'b1;
            rstb_q    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_idx   <= '0;
            exp_qn    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            d_q       <= d_nxt;
            clk_q     <= clk_nxt;
            setb_q    <= setb_nxt;
            rstb_q    <= rstb_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            vec_idx   <= vec_nxt;
            exp_qn    <= exp_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    if (cnt == INIT_LAST) state_nxt = CLKLO;
            CLKLO:   state_nxt = SETUP;
            SETUP:   state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = (vec_idx < LAST_VEC) ? CLKLO : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of all registered outputs
    always_comb begin
        cnt_nxt  = (state_nxt == state) ? cnt + CNT_W'(1) : '0;
        d_nxt    = d_q;
        clk_nxt  = clk_q;
        setb_nxt = setb_q;
        rstb_nxt = rstb_q;
        busy_nxt = 1'b1;
        done_nxt = 1'b0;
        pass_nxt = pass;
        err_nxt  = err_count;
        vec_nxt  = vec_idx;
        exp_nxt  = exp_qn;

        if (state == IDLE && start) begin
            err_nxt  = '0;
            pass_nxt = 1'b0;
            vec_nxt  = '0;
        end

        if (state == CHECK) begin
            // Written as equal/else so an unknown dut_qn lands in the
            // mismatch branch rather than being silently skipped.
            if (lat.dut_qn == exp_qn)
                err_nxt = err_count;
            else if (err_count != '1)
                err_nxt = err_count + ERR_W'(1);
            if (state_nxt == CLKLO)
                vec_nxt = vec_idx + 4'd1;
        end

        case (state_nxt)
            IDLE, DONE: begin
                d_nxt    = 1'b0;
                clk_nxt  = 1'b0;
                setb_nxt = 1'b1;
                rstb_nxt = 1'b1;
                busy_nxt = 1'b0;
                if (state_nxt == DONE) begin
                    done_nxt = 1'b1;
                    pass_nxt = (err_nxt == '0);
                end
            end
            INIT: begin
                d_nxt    = 1'b0;
                clk_nxt  = 1'b0;
                setb_nxt = 1'b0;
                rstb_nxt = 1'b1;
                exp_nxt  = 1'b0;
            end
            CLKLO: clk_nxt = 1'b0;
            SETUP: begin
                d_nxt    = vec_nxt[0];
                clk_nxt  = 1'b0;
                rstb_nxt = vec_nxt[2];
                setb_nxt = vec_nxt[3];
            end
            APPLY: begin
                clk_nxt = vec_nxt[1];
                // Reference latch: set beats reset beats transparent load.
                if (!vec_nxt[3])
                    exp_nxt = 1'b0;
                else if (!vec_nxt[2])
                    exp_nxt = 1'b1;
                else if (vec_nxt[1])
                    exp_nxt = ~vec_nxt[0];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/latch_sr_checker.md
LATCH_SR_CHECKER -- requirements
Module: latch_sr_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 16, gives the number of stimulus vectors per run (1..16).
REQ-002 Parameter SETTLE_CYCLES, default 2, gives the wait cycles between applying the latch enable and sampling dut_qn (>=1).
REQ-003 Parameter ERR_W, default 8, gives the width of the mismatch counter.
REQ-004 Port CLK, input, 1, is the system clock; all state updates on its rising edge.
REQ-005 Port RSTB, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port start, input, 1, is a one-cycle run request, sampled in IDLE only.
REQ-007 Port dut_qn, input, 1, is the inverted output of the set/reset latch under test.
REQ-008 Port dut_d, output, 1, drives the latch data input.
REQ-009 Port dut_clk, output, 1, drives the latch enable (transparent when 1).
REQ-010 Port dut_setb, output, 1, drives the latch active-low set; it forces QN=0.
REQ-011 Port dut_rstb, output, 1, drives the latch active-low reset; it forces QN=1 when dut_setb=1.
REQ-012 Port busy, output, 1, is high from the cycle after start is accepted until done.
REQ-013 Port done, output, 1, is a one-cycle pulse at the end of a run.
REQ-014 Port pass, output, 1, is 1 when the last run had zero mismatches; it holds until the next start.
REQ-015 Port err_count, output, ERR_W, is the mismatch count of the current or last run.
REQ-016 Port vec_idx, output, 4, is the index of the vector currently applied.

Function
REQ-017 The FSM states SHALL be IDLE, INIT, CLKLO, SETUP, APPLY, SETTLE, CHECK, DONE.
REQ-018 Park values SHALL be dut_setb=1, dut_rstb=1, dut_clk=0, dut_d=0, held in IDLE and DONE.
REQ-019 In IDLE with start=1, the FSM SHALL clear err_count, clear pass, set vec_idx=0, and go to INIT.
REQ-020 INIT SHALL drive dut_setb=0, dut_rstb=1, dut_clk=0, dut_d=0 for SETTLE_CYCLES+1 cycles, set exp_qn=0 without checking, then go to CLKLO.
REQ-021 Vector v=vec_idx SHALL map to bits: dut_d=v[0], dut_clk=v[1], dut_rstb=v[2], dut_setb=v[3].
REQ-022 CLKLO (1 cycle) SHALL drive dut_clk=0 and hold the other outputs at their previous values.
REQ-023 SETUP (1 cycle) SHALL drive dut_d, dut_setb, dut_rstb from v, with dut_clk=0.
REQ-024 APPLY (1 cycle) SHALL drive dut_clk=v[1] and update exp_qn per the following priority:
- setb=0 -> 0;
- else rstb=0 -> 1;
- else clk=1 -> ~d;
- else hold.
REQ-025 SETTLE SHALL last SETTLE_CYCLES cycles with outputs unchanged.
REQ-026 CHECK (1 cycle) SHALL compare dut_qn with exp_qn and, on inequality, increment err_count, saturating at 2^ERR_W-1.
REQ-027 After CHECK, the FSM SHALL go to CLKLO with vec_idx+1 if vec_idx<NUM_VECTORS-1, else to DONE.
REQ-028 DONE SHALL pulse done for 1 cycle, set pass=(err_count==0), deassert busy, and return to IDLE.
REQ-029 Per-vector latency SHALL be 4+SETTLE_CYCLES cycles.
REQ-030 Run length from start to done SHALL be (SETTLE_CYCLES+1)+NUM_VECTORS*(4+SETTLE_CYCLES)+1 cycles.
REQ-031 start while busy SHALL be ignored.
REQ-032 An X on dut_qn in CHECK SHALL count as a mismatch.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 RSTB=0 SHALL immediately force IDLE, park values, busy=0, done=0, pass=0, err_count=0, vec_idx=0, exp_qn=0.
REQ-035 Reset mid-run SHALL abort the run with no done pulse; the next start SHALL begin again from INIT.

Verification
REQ-036 Behavioural SR latch connected, defaults, start pulse -> done after 100 cycles, pass=1, err_count=0.
REQ-037 dut_qn tied 0, defaults -> err_count=7 (vectors 8..14), pass=0.
REQ-038 dut_qn tied 1, defaults -> err_count=9, pass=0.
REQ-039 ERR_W=2, dut_qn tied 1 -> err_count saturates at 3.
REQ-040 RSTB pulsed low during vector 5 -> outputs park at once, no done; re-start -> clean pass.
REQ-041 start re-asserted while busy -> no restart, and vec_idx continues monotonically.
